// File: rtl/dpc_sequencer.sv
// dpc_sequencer: DekatronPC fetch / execute / console-I/O control FSM with step budget and retire count.
// Optional feature: define DPC_BREAKPOINT_EN to build in the IpAddress == BreakAddr halt.
module dpc_sequencer #(
    parameter int unsigned INSN_WIDTH   = 4,
    parameter int unsigned CIO_CHANNELS = 2,
    parameter int unsigned STEP_WIDTH   = 8,
    parameter int unsigned IRET_WIDTH   = 32,
    parameter int unsigned IP_WIDTH     = 24,
    localparam int unsigned SEL_WIDTH   = (CIO_CHANNELS > 1) ? $clog2(CIO_CHANNELS) : 1
) (
    input  logic                    Clk,
    input  logic                    Rst_n,
    input  logic                    Halt,
    input  logic                    Step,
    input  logic                    Run,
    input  logic [STEP_WIDTH-1:0]   StepCount,
    input  logic                    EchoMode,
    output logic                    IpRequest,
    input  logic                    IpReady,
    input  logic [INSN_WIDTH-1:0]   Insn,
    input  logic [IP_WIDTH-1:0]     IpAddress,
    input  logic                    DataZero,
    input  logic                    ApZero,
    output logic                    ApRequest,
    output logic                    DataRequest,
    output logic                    ApDec,
    output logic                    ApZeroOp,
    output logic                    ApCin,
    input  logic                    ApReady,
    input  logic [SEL_WIDTH-1:0]    CioSel,
    output logic [CIO_CHANNELS-1:0] CoutReq,
    output logic [CIO_CHANNELS-1:0] CinReq,
    input  logic [CIO_CHANNELS-1:0] CioAcq,
    input  logic [IP_WIDTH-1:0]     BreakAddr,
    output logic [2:0]              State,
    output logic [2:0]              HaltReason,
    output logic                    InsnMode,
    output logic [IRET_WIDTH-1:0]   Iret
);

    typedef enum logic [2:0] {
        StIdle   = 3'd1,
        StFetch  = 3'd2,
        StExec   = 3'd3,
        StHalt   = 3'd4,
        StCin    = 3'd5,
        StCout   = 3'd6,
        StCioAcq = 3'd7
    } stateT;

    localparam logic [2:0] ReasonReset = 3'd0;
    localparam logic [2:0] ReasonInsn  = 3'd1;
    localparam logic [2:0] ReasonExt   = 3'd2;
    localparam logic [2:0] ReasonStep  = 3'd3;
`ifdef DPC_BREAKPOINT_EN
    localparam logic [2:0] ReasonBreak = 3'd4;
`endif

    stateT                   stateQ, stateD;
    logic [2:0]              reasonQ, reasonD;
    logic                    modeQ, modeD;
    logic [IRET_WIDTH-1:0]   iretQ, iretD;
    logic [STEP_WIDTH-1:0]   stepQ, stepD;
    logic                    ipReqQ, ipReqD;
    logic                    apReqQ, apReqD;
    logic                    dataReqQ, dataReqD;
    logic                    apDecQ, apDecD;
    logic                    apZeroOpQ, apZeroOpD;
    logic                    apCinQ, apCinD;
    logic [CIO_CHANNELS-1:0] coutQ, coutD;
    logic [CIO_CHANNELS-1:0] cinQ, cinD;
    logic [SEL_WIDTH-1:0]    chanQ, chanD;
    logic                    echoQ, echoD;
`ifdef DPC_BREAKPOINT_EN
    logic                    skipQ, skipD;
`else
    logic                    unusedBreak;
    assign unusedBreak = ^{IpAddress, BreakAddr};
`endif

    logic [3:0]           op;
    logic                 loopZ;
    logic                 apIdle;
    logic [SEL_WIDTH-1:0] selClamped;

    assign op    = Insn[3:0];
    assign loopZ = modeQ ? DataZero : ApZero;
    // A pulse issued last cycle has not reached the AP line yet, so its Ready is stale.
    assign apIdle = ApReady && !apReqQ && !dataReqQ;

    always_comb begin
        selClamped = CioSel;
        if (32'(CioSel) >= CIO_CHANNELS) begin
            selClamped = '0;
        end
    end

    // State and registered outputs.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            stateQ    <= StHalt;
            reasonQ   <= ReasonReset;
            modeQ     <= 1'b1;
            iretQ     <= '0;
            stepQ     <= '0;
            ipReqQ    <= 1'b0;
            apReqQ    <= 1'b0;
            dataReqQ  <= 1'b0;
            apDecQ    <= 1'b0;
            apZeroOpQ <= 1'b0;
            apCinQ    <= 1'b0;
            coutQ     <= '0;
            cinQ      <= '0;
            chanQ     <= '0;
            echoQ     <= 1'b0;
`ifdef DPC_BREAKPOINT_EN
            skipQ     <= 1'b0;
`endif
        end else begin
            stateQ    <= stateD;
            reasonQ   <= reasonD;
            modeQ     <= modeD;
            iretQ     <= iretD;
            stepQ     <= stepD;
            ipReqQ    <= ipReqD;
            apReqQ    <= apReqD;
            dataReqQ  <= dataReqD;
            apDecQ    <= apDecD;
            apZeroOpQ <= apZeroOpD;
            apCinQ    <= apCinD;
            coutQ     <= coutD;
            cinQ      <= cinD;
            chanQ     <= chanD;
            echoQ     <= echoD;
`ifdef DPC_BREAKPOINT_EN
            skipQ     <= skipD;
`endif
        end
    end

    always_comb begin
        stateD    = stateQ;
        reasonD   = reasonQ;
        modeD     = modeQ;
        iretD     = iretQ;
        stepD     = stepQ;
        ipReqD    = 1'b0;
        apReqD    = 1'b0;
        dataReqD  = 1'b0;
        apDecD    = apDecQ;
        apZeroOpD = apZeroOpQ;
        apCinD    = apCinQ;
        coutD     = coutQ;
        cinD      = cinQ;
        chanD     = chanQ;
        echoD     = echoQ;
`ifdef DPC_BREAKPOINT_EN
        skipD     = skipQ;
`endif

        unique case (stateQ)
            StHalt: begin
                if (Step) begin
                    stepD  = (StepCount == '0) ? STEP_WIDTH'(1) : StepCount;
                    stateD = StIdle;
`ifdef DPC_BREAKPOINT_EN
                    skipD  = 1'b1;
`endif
                end else if (Run) begin
                    stepD  = '0;
                    stateD = StIdle;
`ifdef DPC_BREAKPOINT_EN
                    skipD  = 1'b1;
`endif
                end
            end

            StIdle: begin
`ifdef DPC_BREAKPOINT_EN
                skipD = 1'b0;
`endif
                if (Halt) begin
                    stateD  = StHalt;
                    reasonD = ReasonExt;
`ifdef DPC_BREAKPOINT_EN
                end else if (!skipQ && (IpAddress == BreakAddr)) begin
                    stateD  = StHalt;
                    reasonD = ReasonBreak;
`endif
                end else begin
                    ipReqD = 1'b1;
                    stateD = StFetch;
                end
            end

            StFetch: begin
                // Ready seen in the request cycle still belongs to the previous fetch.
                if (IpReady && !ipReqQ) begin
                    stateD = StExec;
                    casez ({modeQ, op})
                        5'b?0001: begin
                            stateD  = StHalt;
                            reasonD = ReasonInsn;
                        end
                        5'b?0110: begin
                            if (loopZ) begin
                                ipReqD = 1'b1;
                                stateD = StFetch;
                            end
                        end
                        5'b?0111: begin
                            if (!loopZ) begin
                                ipReqD = 1'b1;
                                stateD = StFetch;
                            end
                        end
                        5'b?1010: begin
                            dataReqD  = 1'b1;
                            apZeroOpD = 1'b1;
                        end
                        5'b01011: begin
                            apReqD    = 1'b1;
                            apZeroOpD = 1'b1;
                        end
                        5'b1001?: begin
                            dataReqD = 1'b1;
                            apDecD   = op[0];
                        end
                        5'b1010?: begin
                            apReqD = 1'b1;
                            apDecD = op[0];
                        end
                        5'b11000: begin
                            chanD             = selClamped;
                            coutD[selClamped] = 1'b1;
                            stateD            = StCout;
                        end
                        5'b11001: begin
                            chanD            = selClamped;
                            cinD[selClamped] = 1'b1;
                            stateD           = StCin;
                        end
                        5'b?1110: modeD = 1'b0;
                        5'b?1111: modeD = 1'b1;
                        default: ;  // NOP and unassigned codes retire as NOP
                    endcase
                end
            end

            StExec: begin
                apDecD    = 1'b0;
                apZeroOpD = 1'b0;
                apCinD    = 1'b0;
                if (apIdle) begin
                    iretD = iretQ + IRET_WIDTH'(1);
                    if (stepQ != '0) begin
                        stepD = stepQ - STEP_WIDTH'(1);
                    end
                    if (Halt) begin
                        stateD  = StHalt;
                        reasonD = ReasonExt;
                    end else if (stepQ == STEP_WIDTH'(1)) begin
                        stateD  = StHalt;
                        reasonD = ReasonStep;
                    end else begin
`ifdef DPC_BREAKPOINT_EN
                        // Route through IDLE so every fetch passes the breakpoint compare.
                        stateD = StIdle;
`else
                        ipReqD = 1'b1;
                        stateD = StFetch;
`endif
                    end
                end
            end

            StCout: begin
                if (CioAcq[chanQ]) begin
                    coutD[chanQ] = 1'b0;
                    stateD       = StCioAcq;
                end
            end

            StCin: begin
                if (CioAcq[chanQ]) begin
                    cinD[chanQ] = 1'b0;
                    dataReqD    = 1'b1;
                    apCinD      = 1'b1;
                    echoD       = EchoMode;
                    stateD      = StCioAcq;
                end
            end

            StCioAcq: begin
                if (apIdle && !CioAcq[chanQ]) begin
                    if (echoQ) begin
                        echoD        = 1'b0;
                        coutD[chanQ] = 1'b1;
                        stateD       = StCout;
                    end else begin
                        stateD = StExec;
                    end
                end
            end

            default: stateD = StIdle;
        endcase
    end

    always_comb begin
        State       = stateQ;
        HaltReason  = reasonQ;
        InsnMode    = modeQ;
        Iret        = iretQ;
        IpRequest   = ipReqQ;
        ApRequest   = apReqQ;
        DataRequest = dataReqQ;
        ApDec       = apDecQ;
        ApZeroOp    = apZeroOpQ;
        ApCin       = apCinQ;
        CoutReq     = coutQ;
        CinReq      = cinQ;
    end

endmodule

// File: tb/tb_dpc_sequencer.sv
// Directed bench for dpc_sequencer with small IpLine / ApLine responders.
module tb_dpc_sequencer;

    logic        Clk;
    logic        Rst_n;
    logic        Halt, Step, Run;
    logic [7:0]  StepCount;
    logic        EchoMode;
    logic        IpRequest, IpReady;
    logic [3:0]  Insn;
    logic [23:0] IpAddress;
    logic        DataZero, ApZero;
    logic        ApRequest, DataRequest, ApDec, ApZeroOp, ApCin, ApReady;
    logic [0:0]  CioSel;
    logic [1:0]  CoutReq, CinReq, CioAcq;
    logic [23:0] BreakAddr;
    logic [2:0]  State, HaltReason;
    logic        InsnMode;
    logic [31:0] Iret;

    int compared   = 0;
    int mismatched = 0;

    logic [3:0] prog [0:31];
    int ipPtr;
    int ipReqCount, apReqCount, dataReqCount, decCount, zeroOpCount, cinOpCount;
    int execCount, wideCount, chan0Count;

    dpc_sequencer #(
        .INSN_WIDTH  (4),
        .CIO_CHANNELS(2),
        .STEP_WIDTH  (8),
        .IRET_WIDTH  (32),
        .IP_WIDTH    (24)
    ) dut (
        .Clk        (Clk),
        .Rst_n      (Rst_n),
        .Halt       (Halt),
        .Step       (Step),
        .Run        (Run),
        .StepCount  (StepCount),
        .EchoMode   (EchoMode),
        .IpRequest  (IpRequest),
        .IpReady    (IpReady),
        .Insn       (Insn),
        .IpAddress  (IpAddress),
        .DataZero   (DataZero),
        .ApZero     (ApZero),
        .ApRequest  (ApRequest),
        .DataRequest(DataRequest),
        .ApDec      (ApDec),
        .ApZeroOp   (ApZeroOp),
        .ApCin      (ApCin),
        .ApReady    (ApReady),
        .CioSel     (CioSel),
        .CoutReq    (CoutReq),
        .CinReq     (CinReq),
        .CioAcq     (CioAcq),
        .BreakAddr  (BreakAddr),
        .State      (State),
        .HaltReason (HaltReason),
        .InsnMode   (InsnMode),
        .Iret       (Iret)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    // IpLine: each request advances and presents prog[ipPtr] one cycle later.
    initial begin
        IpReady = 1'b1;
        Insn    = 4'h0;
        forever begin
            @(posedge Clk); #1;
            if (IpRequest === 1'b1) begin
                ipReqCount++;
                IpReady = 1'b0;
                @(posedge Clk); #1;
                Insn      = prog[ipPtr];
                ipPtr     = ipPtr + 1;
                IpAddress = 24'(ipPtr);
                IpReady   = 1'b1;
            end
        end
    end

    // ApLine: busy for one cycle after each operation pulse.
    initial begin
        ApReady = 1'b1;
        forever begin
            @(posedge Clk); #1;
            if (ApRequest === 1'b1 || DataRequest === 1'b1) begin
                if (ApRequest === 1'b1) apReqCount++;
                if (DataRequest === 1'b1) dataReqCount++;
                if (ApDec === 1'b1) decCount++;
                if (ApZeroOp === 1'b1) zeroOpCount++;
                if (ApCin === 1'b1) cinOpCount++;
                ApReady = 1'b0;
                @(posedge Clk); #1;
                ApReady = 1'b1;
            end
        end
    end

    initial begin
        logic [2:0] prevState;
        logic       prevIp, prevAp, prevData;
        prevState = 3'd0;
        prevIp = 1'b0; prevAp = 1'b0; prevData = 1'b0;
        forever begin
            @(posedge Clk); #1;
            if (State == 3'd3 && prevState != 3'd3) execCount++;
            if ((IpRequest && prevIp) || (ApRequest && prevAp) || (DataRequest && prevData))
                wideCount++;
            if (CoutReq[0] || CinReq[0]) chan0Count++;
            prevState = State;
            prevIp = IpRequest; prevAp = ApRequest; prevData = DataRequest;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not reach the summary");
        $fatal(1);
    end

    task automatic applyReset();
        Rst_n = 1'b0;
        Halt = 1'b0; Step = 1'b0; Run = 1'b0; StepCount = 8'd0; EchoMode = 1'b0;
        DataZero = 1'b0; ApZero = 1'b0; CioSel = 1'b0; CioAcq = 2'b00;
        BreakAddr = 24'hFFFFFF;
        for (int i = 0; i < 32; i++) prog[i] = 4'h1;
        repeat (3) @(posedge Clk);
        #1;
        ipPtr = 0; IpAddress = 24'd0;
        ipReqCount = 0; apReqCount = 0; dataReqCount = 0; decCount = 0;
        zeroOpCount = 0; cinOpCount = 0; execCount = 0; wideCount = 0; chan0Count = 0;
        Rst_n = 1'b1;
        @(posedge Clk); #1;
    endtask

    task automatic pulseRun();
        Run = 1'b1;
        @(posedge Clk); #1;
        Run = 1'b0;
    endtask

    task automatic pulseStep();
        Step = 1'b1;
        @(posedge Clk); #1;
        Step = 1'b0;
    endtask

    task automatic waitHalt(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (State == 3'd4) begin
                ok = 1'b1;
                break;
            end
            @(posedge Clk); #1;
        end
    endtask

    task automatic test_reset();
        applyReset();
        compared++;
        if (State !== 3'd4) begin mismatched++; $display("FAIL reset_state: got %0d want 4", State); end
        compared++;
        if (HaltReason !== 3'd0) begin
            mismatched++; $display("FAIL reset_reason: got %0d want 0", HaltReason);
        end
        compared++;
        if (InsnMode !== 1'b1) begin mismatched++; $display("FAIL reset_mode: got %0d want 1", InsnMode); end
        compared++;
        if (Iret !== 32'd0) begin mismatched++; $display("FAIL reset_iret: got %0d want 0", Iret); end
        compared++;
        if ({IpRequest, ApRequest, DataRequest, ApDec, ApZeroOp, ApCin, CoutReq, CinReq} !== 10'd0) begin
            mismatched++;
            $display("FAIL reset_outputs: got %b want 0", {IpRequest, ApRequest, DataRequest,
                     ApDec, ApZeroOp, ApCin, CoutReq, CinReq});
        end
        // Async reset while a console request is up.
        prog[0] = 4'h8;
        CioSel = 1'b1;
        pulseRun();
        for (int i = 0; i < 50 && CoutReq == 2'b00; i++) begin @(posedge Clk); #1; end
        Rst_n = 1'b0;
        #1;
        compared++;
        if (CoutReq !== 2'b00 || State !== 3'd4) begin
            mismatched++;
            $display("FAIL reset_async: got CoutReq=%b State=%0d want 00 / 4", CoutReq, State);
        end
    endtask

    task automatic test_run_program();
        bit ok;
        applyReset();
        prog[0] = 4'h2; prog[1] = 4'h2; prog[2] = 4'h1;
        pulseRun();
        compared++;
        if (State !== 3'd1) begin mismatched++; $display("FAIL run_idle: got %0d want 1", State); end
        @(posedge Clk); #1;
        compared++;
        if (IpRequest !== 1'b1 || State !== 3'd2) begin
            mismatched++;
            $display("FAIL run_first_fetch: got IpRequest=%0d State=%0d want 1 / 2", IpRequest, State);
        end
        waitHalt(ok);
        compared++;
        if (!ok) begin mismatched++; $display("FAIL run_halt: got no halt want halt"); end
        compared++;
        if (dataReqCount !== 2 || decCount !== 0) begin
            mismatched++;
            $display("FAIL run_datareq: got %0d pulses dec=%0d want 2 / 0", dataReqCount, decCount);
        end
        compared++;
        if (Iret !== 32'd2) begin mismatched++; $display("FAIL run_iret: got %0d want 2", Iret); end
        compared++;
        if (HaltReason !== 3'd1) begin
            mismatched++; $display("FAIL run_reason: got %0d want 1", HaltReason);
        end
        compared++;
        if (wideCount !== 0) begin mismatched++; $display("FAIL pulse_width: got %0d want 0", wideCount); end
    endtask

    task automatic test_step();
        bit ok;
        applyReset();
        for (int i = 0; i < 16; i++) prog[i] = 4'h2;
        StepCount = 8'd3;
        pulseStep();
        waitHalt(ok);
        compared++;
        if (!ok || Iret !== 32'd3 || HaltReason !== 3'd3) begin
            mismatched++;
            $display("FAIL step3: got Iret=%0d reason=%0d want 3 / 3", Iret, HaltReason);
        end
        compared++;
        if (dataReqCount !== 3) begin mismatched++; $display("FAIL step3_ops: got %0d want 3", dataReqCount); end
        StepCount = 8'd0;
        pulseStep();
        waitHalt(ok);
        compared++;
        if (!ok || Iret !== 32'd4 || HaltReason !== 3'd3) begin
            mismatched++;
            $display("FAIL step0: got Iret=%0d reason=%0d want 4 / 3", Iret, HaltReason);
        end
        // Step wins over Run when both are up.
        applyReset();
        for (int i = 0; i < 10; i++) prog[i] = 4'h2;
        StepCount = 8'd1;
        Run = 1'b1;
        Step = 1'b1;
        @(posedge Clk); #1;
        Run = 1'b0;
        Step = 1'b0;
        waitHalt(ok);
        compared++;
        if (!ok || Iret !== 32'd1 || HaltReason !== 3'd3) begin
            mismatched++;
            $display("FAIL step_priority: got Iret=%0d reason=%0d want 1 / 3", Iret, HaltReason);
        end
    endtask

    task automatic test_halt_ext();
        bit ok;
        applyReset();
        Halt = 1'b1;
        pulseRun();
        @(posedge Clk); #1;
        compared++;
        if (State !== 3'd4 || HaltReason !== 3'd2 || ipReqCount !== 0) begin
            mismatched++;
            $display("FAIL halt_idle: got State=%0d reason=%0d fetches=%0d want 4 / 2 / 0",
                     State, HaltReason, ipReqCount);
        end
        Halt = 1'b0;
        // Halt raised during the second fetch is taken after that instruction retires.
        applyReset();
        for (int i = 0; i < 16; i++) prog[i] = 4'h2;
        pulseRun();
        repeat (6) begin @(posedge Clk); #1; end
        Halt = 1'b1;
        waitHalt(ok);
        Halt = 1'b0;
        compared++;
        if (!ok || Iret !== 32'd2 || HaltReason !== 3'd2 || dataReqCount !== 2) begin
            mismatched++;
            $display("FAIL halt_exec: got Iret=%0d reason=%0d ops=%0d want 2 / 2 / 2",
                     Iret, HaltReason, dataReqCount);
        end
    endtask

    task automatic test_cout();
        bit ok;
        applyReset();
        prog[0] = 4'h8;
        CioSel = 1'b1;
        pulseRun();
        for (int i = 0; i < 50 && CoutReq == 2'b00; i++) begin @(posedge Clk); #1; end
        compared++;
        if (CoutReq !== 2'b10) begin mismatched++; $display("FAIL cout_raise: got %b want 10", CoutReq); end
        repeat (3) begin @(posedge Clk); #1; end
        compared++;
        if (CoutReq !== 2'b10 || Iret !== 32'd0) begin
            mismatched++; $display("FAIL cout_hold: got %b Iret=%0d want 10 / 0", CoutReq, Iret);
        end
        CioAcq = 2'b10;
        @(posedge Clk); #1;
        compared++;
        if (CoutReq !== 2'b00) begin mismatched++; $display("FAIL cout_drop: got %b want 00", CoutReq); end
        CioAcq = 2'b00;
        waitHalt(ok);
        compared++;
        if (!ok || Iret !== 32'd1 || HaltReason !== 3'd1 || chan0Count !== 0) begin
            mismatched++;
            $display("FAIL cout_retire: got Iret=%0d reason=%0d ch0=%0d want 1 / 1 / 0",
                     Iret, HaltReason, chan0Count);
        end
    endtask

    task automatic test_cin_echo();
        bit ok;
        applyReset();
        prog[0] = 4'h9;
        CioSel = 1'b1;
        EchoMode = 1'b1;
        pulseRun();
        for (int i = 0; i < 50 && CinReq == 2'b00; i++) begin @(posedge Clk); #1; end
        compared++;
        if (CinReq !== 2'b10 || CoutReq !== 2'b00) begin
            mismatched++; $display("FAIL cin_raise: got Cin=%b Cout=%b want 10 / 00", CinReq, CoutReq);
        end
        CioAcq = 2'b10;
        @(posedge Clk); #1;
        compared++;
        if (CinReq !== 2'b00 || {DataRequest, ApCin} !== 2'b11) begin
            mismatched++;
            $display("FAIL cin_store: got Cin=%b DataRequest=%0d ApCin=%0d want 00 / 1 / 1",
                     CinReq, DataRequest, ApCin);
        end
        CioAcq = 2'b00;
        for (int i = 0; i < 50 && CoutReq == 2'b00; i++) begin @(posedge Clk); #1; end
        compared++;
        if (CoutReq !== 2'b10) begin mismatched++; $display("FAIL cin_echo: got %b want 10", CoutReq); end
        CioAcq = 2'b10;
        @(posedge Clk); #1;
        CioAcq = 2'b00;
        waitHalt(ok);
        compared++;
        if (!ok || Iret !== 32'd1 || cinOpCount !== 1 || dataReqCount !== 1 || chan0Count !== 0) begin
            mismatched++;
            $display("FAIL cin_retire: got Iret=%0d cin=%0d data=%0d ch0=%0d want 1 / 1 / 1 / 0",
                     Iret, cinOpCount, dataReqCount, chan0Count);
        end
    endtask

    task automatic test_loops();
        bit ok;
        applyReset();
        DataZero = 1'b1;
        prog[0] = 4'h6;
        pulseRun();
        waitHalt(ok);
        compared++;
        if (!ok || Iret !== 32'd0 || execCount !== 0 || ipReqCount !== 2) begin
            mismatched++;
            $display("FAIL loop_open_skip: got Iret=%0d exec=%0d fetch=%0d want 0 / 0 / 2",
                     Iret, execCount, ipReqCount);
        end
        applyReset();
        prog[0] = 4'h7;
        pulseRun();
        waitHalt(ok);
        compared++;
        if (!ok || Iret !== 32'd0 || execCount !== 0 || ipReqCount !== 2) begin
            mismatched++;
            $display("FAIL loop_close_back: got Iret=%0d exec=%0d fetch=%0d want 0 / 0 / 2",
                     Iret, execCount, ipReqCount);
        end
        applyReset();
        prog[0] = 4'h6;
        pulseRun();
        waitHalt(ok);
        compared++;
        if (!ok || Iret !== 32'd1 || execCount !== 1) begin
            mismatched++;
            $display("FAIL loop_open_enter: got Iret=%0d exec=%0d want 1 / 1", Iret, execCount);
        end
        applyReset();
        ApZero = 1'b1;
        prog[0] = 4'hE; prog[1] = 4'h6;
        pulseRun();
        waitHalt(ok);
        compared++;
        if (!ok || Iret !== 32'd1 || ipReqCount !== 3 || InsnMode !== 1'b0) begin
            mismatched++;
            $display("FAIL loop_debug_apzero: got Iret=%0d fetch=%0d mode=%0d want 1 / 3 / 0",
                     Iret, ipReqCount, InsnMode);
        end
    endtask

    task automatic test_ap_ops();
        bit ok;
        applyReset();
        prog[0] = 4'h4; prog[1] = 4'h5; prog[2] = 4'hE; prog[3] = 4'hA; prog[4] = 4'hB;
        pulseRun();
        waitHalt(ok);
        compared++;
        if (!ok || Iret !== 32'd5 || InsnMode !== 1'b0) begin
            mismatched++; $display("FAIL ap_ops_retire: got Iret=%0d mode=%0d want 5 / 0", Iret, InsnMode);
        end
        compared++;
        if (apReqCount !== 3 || dataReqCount !== 1 || decCount !== 1 || zeroOpCount !== 2) begin
            mismatched++;
            $display("FAIL ap_ops_pulses: got ap=%0d data=%0d dec=%0d zero=%0d want 3 / 1 / 1 / 2",
                     apReqCount, dataReqCount, decCount, zeroOpCount);
        end
    endtask

    task automatic test_breakpoint();
        bit ok;
        applyReset();
`ifdef DPC_BREAKPOINT_EN
        for (int i = 0; i < 8; i++) prog[i] = 4'h2;
        BreakAddr = 24'd5;
        pulseRun();
        waitHalt(ok);
        compared++;
        if (!ok || HaltReason !== 3'd4 || Iret !== 32'd5 || IpAddress !== 24'd5) begin
            mismatched++;
            $display("FAIL break_hit: got reason=%0d Iret=%0d ip=%0d want 4 / 5 / 5",
                     HaltReason, Iret, IpAddress);
        end
        pulseRun();
        waitHalt(ok);
        compared++;
        if (!ok || HaltReason !== 3'd1 || Iret !== 32'd8) begin
            mismatched++;
            $display("FAIL break_resume: got reason=%0d Iret=%0d want 1 / 8", HaltReason, Iret);
        end
`else
        prog[0] = 4'h2; prog[1] = 4'h2;
        BreakAddr = 24'd1;
        pulseRun();
        waitHalt(ok);
        compared++;
        if (!ok || HaltReason !== 3'd1 || Iret !== 32'd2) begin
            mismatched++;
            $display("FAIL break_absent: got reason=%0d Iret=%0d want 1 / 2", HaltReason, Iret);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_run_program();
        test_step();
        test_halt_ext();
        test_cout();
        test_cin_echo();
        test_loops();
        test_ap_ops();
        test_breakpoint();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
